// File: rtl/sh_align_pkg.sv
// Shared definitions for the sync-header block aligner and related gearbox logic.
// Contents: word/header/payload/offset widths, the sync-header encodings,
// the state encoding of the alignment state machine and a header validity helper.
package sh_align_pkg;

    localparam int WORD_W = 60;
    localparam int HDR_W  = 2;
    localparam int PAY_W  = 58;
    localparam int OFS_W  = 6;

    // Valid sync headers; 2'b00 and 2'b11 are illegal on the line.
    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    // Alignment state machine encoding.
    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SLIP   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    // A header is valid exactly when its two bits differ.
    function automatic logic hdr_is_valid(input logic [HDR_W-1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/sh_barrel_window.sv
// 120-to-60 bit window select used for block alignment (RX) and gearboxing (TX).
// Ports:
//   win_i  - two concatenated words, bit 0 earliest received
//   ofs_i  - start bit of the extracted word, 0..59
//   word_o - win_i[ofs_i+59 : ofs_i]
// Purely combinational.
module sh_barrel_window
    import sh_align_pkg::*;
(
    input  logic [2*WORD_W-1:0] win_i,
    input  logic [OFS_W-1:0]    ofs_i,
    output logic [WORD_W-1:0]   word_o
);

    // Offset select; the index is widened so it can address the full 120-bit window.
    always_comb begin
        word_o = win_i[{1'b0, ofs_i} +: WORD_W];
    end

endmodule

// File: rtl/sh_block_aligner.sv
// Sync-header block aligner: finds 60-bit block boundaries in the deserializer
// output using the 2-bit sync header, bit-slips until aligned and reports lock.
// Ports:
//   clk_div_60    - word clock
//   rst           - synchronous active-high reset
//   data_parallel - raw 60-bit word, bit 0 earliest received
//   data_out      - aligned payload (aligned bits [59:2])
//   hdr_out       - aligned sync header (aligned bits [1:0])
//   out_valid     - locked and hdr_out is a valid header
//   block_lock    - high while LOCKED
//   hdr_err       - pulse per invalid header evaluated in HUNT or LOCKED
//   slip_ofs      - current alignment offset 0..59
module sh_block_aligner
    import sh_align_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int BAD_CNT   = 16,
    parameter int SLIP_WAIT = 2
)(
    input  logic              clk_div_60,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_parallel,
    output logic [PAY_W-1:0]  data_out,
    output logic [HDR_W-1:0]  hdr_out,
    output logic              out_valid,
    output logic              block_lock,
    output logic              hdr_err,
    output logic [OFS_W-1:0]  slip_ofs
);

    localparam int SH_W  = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(BAD_CNT + 1);
    localparam logic [SH_W-1:0]  LOCK_LAST = SH_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0] BAD_LAST  = BAD_W'(BAD_CNT - 1);
    localparam logic [2:0]       WAIT_INIT = 3'(SLIP_WAIT);
    localparam logic [OFS_W-1:0] OFS_MAX   = 6'd59;

    logic [WORD_W-1:0] prev_word_q;
    logic [WORD_W-1:0] aligned_q;
    logic [WORD_W-1:0] window_s;
    // hist_q: prev_word_q holds a real word; aln_vld_q: aligned_q was built from
    // two real words. Headers taken from reset-zero history are never evaluated.
    logic              hist_q;
    logic              aln_vld_q;
    logic [1:0]        state_q, state_d;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [SH_W-1:0]   win_cnt_q, win_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic [OFS_W-1:0]  slip_ofs_q, slip_ofs_d;
    logic              hdr_ok_s;
    logic              enter_slip_s;
    logic              hdr_err_s;
    logic              lock_s;

    sh_barrel_window u_window (
        .win_i  ({data_parallel, prev_word_q}),
        .ofs_i  (slip_ofs_q),
        .word_o (window_s)
    );

    // Header check on the aligned word.
    always_comb begin
        hdr_ok_s = hdr_is_valid(aligned_q[HDR_W-1:0]);
    end

    // Alignment state machine and its counters.
    always_comb begin
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        win_cnt_d    = win_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        slip_ofs_d   = slip_ofs_q;
        enter_slip_s = 1'b0;
        case (state_q)
            HUNT: begin
                if (!aln_vld_q) begin
                    state_d = HUNT;
                end else if (!hdr_ok_s) begin
                    enter_slip_s = 1'b1;
                end else if (sh_cnt_q == LOCK_LAST) begin
                    state_d   = LOCKED;
                    sh_cnt_d  = '0;
                    win_cnt_d = '0;
                    bad_cnt_d = '0;
                end else begin
                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                end
            end
            SLIP: begin
                // Headers are ignored while the new offset propagates.
                if (wait_cnt_q <= 3'd1) begin
                    state_d    = HUNT;
                    wait_cnt_d = 3'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            LOCKED: begin
                // Unlock takes priority over the end-of-window clear.
                if (!hdr_ok_s && (bad_cnt_q == BAD_LAST)) begin
                    enter_slip_s = 1'b1;
                end else if (win_cnt_q == LOCK_LAST) begin
                    win_cnt_d = '0;
                    bad_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + SH_W'(1);
                    bad_cnt_d = hdr_ok_s ? bad_cnt_q : (bad_cnt_q + BAD_W'(1));
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
        if (enter_slip_s) begin
            state_d    = SLIP;
            sh_cnt_d   = '0;
            wait_cnt_d = WAIT_INIT;
            slip_ofs_d = (slip_ofs_q == OFS_MAX) ? 6'd0 : (slip_ofs_q + 6'd1);
        end else begin
            slip_ofs_d = slip_ofs_d;
        end
    end

    // Stage-2 output qualifiers; lock follows the next state so it drops with the SLIP transition.
    always_comb begin
        lock_s    = (state_d == LOCKED);
        hdr_err_s = aln_vld_q && !hdr_ok_s && ((state_q == HUNT) || (state_q == LOCKED));
    end

    // Pipeline, state and output registers with synchronous reset.
    always_ff @(posedge clk_div_60) begin
        if (rst) begin
            prev_word_q <= '0;
            aligned_q   <= '0;
            hist_q      <= 1'b0;
            aln_vld_q   <= 1'b0;
            state_q     <= HUNT;
            sh_cnt_q    <= '0;
            win_cnt_q   <= '0;
            bad_cnt_q   <= '0;
            wait_cnt_q  <= 3'd0;
            slip_ofs_q  <= 6'd0;
            data_out    <= '0;
            hdr_out     <= 2'b00;
            out_valid   <= 1'b0;
            block_lock  <= 1'b0;
            hdr_err     <= 1'b0;
        end else begin
            prev_word_q <= data_parallel;
            aligned_q   <= window_s;
            hist_q      <= 1'b1;
            aln_vld_q   <= hist_q;
            state_q     <= state_d;
            sh_cnt_q    <= sh_cnt_d;
            win_cnt_q   <= win_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            slip_ofs_q  <= slip_ofs_d;
            data_out    <= aligned_q[WORD_W-1:HDR_W];
            hdr_out     <= aligned_q[HDR_W-1:0];
            out_valid   <= lock_s && hdr_ok_s;
            block_lock  <= lock_s;
            hdr_err     <= hdr_err_s;
        end
    end

    assign slip_ofs = slip_ofs_q;

endmodule

// File: tb/tb_sh_block_aligner.sv
// Directed testbench for sh_block_aligner. Blocks are 60-bit words, header in
// bits [1:0]; a stream at rotation r delivers word k = bits [60k-r +: 60] of the
// serial block stream, so after the edge that samples word k the aligned output
// carries block k-2.
module tb_sh_block_aligner;

    logic        clk_div_60 = 1'b0;
    logic        rst;
    logic [59:0] data_parallel;
    logic [57:0] data_out;
    logic [1:0]  hdr_out;
    logic        out_valid;
    logic        block_lock;
    logic        hdr_err;
    logic [5:0]  slip_ofs;

    int errors = 0;
    int checks = 0;
    logic [59:0] blk [0:2047];

    sh_block_aligner dut (
        .clk_div_60    (clk_div_60),
        .rst           (rst),
        .data_parallel (data_parallel),
        .data_out      (data_out),
        .hdr_out       (hdr_out),
        .out_valid     (out_valid),
        .block_lock    (block_lock),
        .hdr_err       (hdr_err),
        .slip_ofs      (slip_ofs)
    );

    always #5 clk_div_60 = ~clk_div_60;

    task automatic step(input logic [59:0] w);
        data_parallel = w;
        @(posedge clk_div_60);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_parallel = '0;
        @(posedge clk_div_60); #1;
        @(posedge clk_div_60); #1;
        rst = 1'b0;
    endtask

    function automatic logic [59:0] word_at(input int k, input int r);
        logic [119:0] two;
        logic [119:0] sh;
        two = {blk[k], (k > 0) ? blk[k-1] : 60'd0};
        sh  = two >> (60 - r);
        return sh[59:0];
    endfunction

    task automatic fill_blocks(input bit data_only);
        logic [63:0] p;
        for (int j = 0; j < 2048; j++) begin
            p = {$urandom, $urandom};
            blk[j] = {p[57:0], (data_only || $urandom_range(0, 1) == 0) ? 2'b01 : 2'b10};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_parallel = {60{1'b1}};
        @(posedge clk_div_60); #1;
        @(posedge clk_div_60); #1;
        checks++; if (data_out !== 58'd0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if (hdr_out !== 2'b00) begin errors++; $display("FAIL reset_hdr_out got=%b exp=00", hdr_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL reset_block_lock got=%b exp=0", block_lock); end
        checks++; if (hdr_err !== 1'b0) begin errors++; $display("FAIL reset_hdr_err got=%b exp=0", hdr_err); end
        checks++; if (slip_ofs !== 6'd0) begin errors++; $display("FAIL reset_slip_ofs got=%0d exp=0", slip_ofs); end
        rst = 1'b0;
    endtask

    // All-zero stream: every header at every offset is 00, so the aligner slips
    // every 3 edges (eval, then SLIP_WAIT=2 ignored cycles) and wraps 59 -> 0.
    task automatic test_slip_wait();
        int n;
        logic       exp_err;
        logic [5:0] exp_ofs;
        do_reset();
        for (int k = 0; k < 190; k++) begin
            step(60'd0);
            n = (k - 2) / 3;
            exp_err = (k >= 2) && ((k - 2) % 3 == 0);
            exp_ofs = (k >= 2) ? 6'((n + 1) % 60) : 6'd0;
            checks++; if (hdr_err !== exp_err) begin errors++; $display("FAIL slip_hdr_err k=%0d got=%b exp=%b", k, hdr_err, exp_err); end
            checks++; if (slip_ofs !== exp_ofs) begin errors++; $display("FAIL slip_ofs k=%0d got=%0d exp=%0d", k, slip_ofs, exp_ofs); end
            checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL slip_lock k=%0d got=%b exp=0", k, block_lock); end
        end
    endtask

    // Rotation 0, all headers 01: 64th header (block 63) evaluated at edge 65.
    task automatic test_aligned();
        logic [57:0] exp_pay;
        do_reset();
        for (int k = 0; k <= 65; k++) begin
            step(word_at(k, 0));
            exp_pay = (k >= 2) ? blk[k-2][59:2] : 58'd0;
            checks++; if (data_out !== exp_pay) begin errors++; $display("FAIL aligned_data k=%0d got=%h exp=%h", k, data_out, exp_pay); end
            checks++; if (block_lock !== (k == 65)) begin errors++; $display("FAIL aligned_lock k=%0d got=%b exp=%b", k, block_lock, (k == 65)); end
            checks++; if (out_valid !== (k == 65)) begin errors++; $display("FAIL aligned_out_valid k=%0d got=%b exp=%b", k, out_valid, (k == 65)); end
            checks++; if (hdr_err !== 1'b0) begin errors++; $display("FAIL aligned_hdr_err k=%0d got=%b exp=0", k, hdr_err); end
            checks++; if (slip_ofs !== 6'd0) begin errors++; $display("FAIL aligned_ofs k=%0d got=%0d exp=0", k, slip_ofs); end
        end
    endtask

    // First LOCKED window = blocks 64..127 (edges 66..129) with 15 invalid headers.
    task automatic test_err_tolerance();
        int  pulses = 0;
        logic inv;
        for (int k = 66; k <= 129; k++) begin
            step(word_at(k, 0));
            inv = (blk[k-2][1] == blk[k-2][0]);
            if (hdr_err === 1'b1) pulses++;
            checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL tol_lock k=%0d got=%b exp=1", k, block_lock); end
            checks++; if (hdr_err !== inv) begin errors++; $display("FAIL tol_hdr_err k=%0d got=%b exp=%b", k, hdr_err, inv); end
            checks++; if (out_valid !== !inv) begin errors++; $display("FAIL tol_out_valid k=%0d got=%b exp=%b", k, out_valid, !inv); end
            checks++; if ({data_out, hdr_out} !== blk[k-2]) begin errors++; $display("FAIL tol_word k=%0d got=%h exp=%h", k, {data_out, hdr_out}, blk[k-2]); end
        end
        checks++; if (pulses != 15) begin errors++; $display("FAIL tol_pulse_count got=%0d exp=15", pulses); end
    endtask

    // Second window = blocks 128..191; the 16th invalid header is block 191 (edge 193).
    task automatic test_loss_of_lock();
        logic inv;
        logic exp_lock;
        for (int k = 130; k <= 193; k++) begin
            step(word_at(k, 0));
            inv = (blk[k-2][1] == blk[k-2][0]);
            exp_lock = (k <= 192);
            checks++; if (block_lock !== exp_lock) begin errors++; $display("FAIL loss_lock k=%0d got=%b exp=%b", k, block_lock, exp_lock); end
            checks++; if (hdr_err !== inv) begin errors++; $display("FAIL loss_hdr_err k=%0d got=%b exp=%b", k, hdr_err, inv); end
            checks++; if (out_valid !== (exp_lock && !inv)) begin errors++; $display("FAIL loss_out_valid k=%0d got=%b exp=%b", k, out_valid, exp_lock && !inv); end
            checks++; if (slip_ofs !== ((k == 193) ? 6'd1 : 6'd0)) begin errors++; $display("FAIL loss_ofs k=%0d got=%0d exp=%0d", k, slip_ofs, (k == 193) ? 1 : 0); end
        end
    endtask

    // Hunt for lock at rotation r, then check 20 aligned blocks; returns next word index.
    task automatic test_rotated(input int r, output int k_next);
        int k = 0;
        bit locked = 1'b0;
        do_reset();
        fill_blocks(1'b0);
        while (!locked && k < 1500) begin
            step(word_at(k, r));
            locked = (block_lock === 1'b1);
            k++;
        end
        checks++; if (!locked) begin errors++; $display("FAIL rot%0d_lock_timeout got=0 exp=1", r); end
        checks++; if (slip_ofs !== 6'(r)) begin errors++; $display("FAIL rot%0d_ofs got=%0d exp=%0d", r, slip_ofs, r); end
        for (int i = 0; i < 20; i++) begin
            step(word_at(k, r));
            checks++; if ({data_out, hdr_out} !== blk[k-2]) begin errors++; $display("FAIL rot%0d_word k=%0d got=%h exp=%h", r, k, {data_out, hdr_out}, blk[k-2]); end
            checks++; if (out_valid !== 1'b1 || hdr_err !== 1'b0 || block_lock !== 1'b1) begin
                errors++; $display("FAIL rot%0d_flags k=%0d got=%b%b%b exp=101", r, k, out_valid, hdr_err, block_lock);
            end
            k++;
        end
        k_next = k;
    endtask

    // Stream shifts by 5 bits (17 -> 22) mid-run: lock drops, then relocks at 22.
    task automatic test_shift_relock(input int k0);
        int k = k0;
        int lim;
        lim = k0 + 400;
        while (block_lock === 1'b1 && k < lim) begin step(word_at(k, 22)); k++; end
        checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL shift_unlock got=%b exp=0", block_lock); end
        lim = k + 1000;
        while (block_lock !== 1'b1 && k < lim) begin step(word_at(k, 22)); k++; end
        checks++; if (block_lock !== 1'b1) begin errors++; $display("FAIL shift_relock got=%b exp=1", block_lock); end
        checks++; if (slip_ofs !== 6'd22) begin errors++; $display("FAIL shift_ofs got=%0d exp=22", slip_ofs); end
        for (int i = 0; i < 10; i++) begin
            step(word_at(k, 22));
            checks++; if ({data_out, hdr_out} !== blk[k-2]) begin errors++; $display("FAIL shift_word k=%0d got=%h exp=%h", k, {data_out, hdr_out}, blk[k-2]); end
            k++;
        end
    endtask

    // One-cycle reset while LOCKED at offset 33 clears everything.
    task automatic test_reset_locked();
        int k;
        test_rotated(33, k);
        rst = 1'b1;
        step(word_at(k, 33));
        rst = 1'b0;
        checks++; if ({data_out, hdr_out} !== 60'd0) begin errors++; $display("FAIL rstlk_word got=%h exp=0", {data_out, hdr_out}); end
        checks++; if ({out_valid, block_lock, hdr_err} !== 3'b000) begin errors++; $display("FAIL rstlk_flags got=%b exp=000", {out_valid, block_lock, hdr_err}); end
        checks++; if (slip_ofs !== 6'd0) begin errors++; $display("FAIL rstlk_ofs got=%0d exp=0", slip_ofs); end
        step(word_at(k + 1, 33));
        step(word_at(k + 2, 33));
        checks++; if ({block_lock, hdr_err, slip_ofs} !== 8'd0) begin errors++; $display("FAIL rstlk_after got=%b exp=0", {block_lock, hdr_err, slip_ofs}); end
    endtask

    initial begin
        int k_next;
        rst = 1'b1;
        data_parallel = '0;
        test_reset();
        test_slip_wait();
        fill_blocks(1'b1);
        for (int i = 0; i < 15; i++) blk[64 + 4*i][1:0] = (i % 2 == 0) ? 2'b00 : 2'b11;
        for (int i = 0; i < 15; i++) blk[128 + 4*i][1:0] = (i % 2 == 0) ? 2'b11 : 2'b00;
        blk[191][1:0] = 2'b00;
        test_aligned();
        test_err_tolerance();
        test_loss_of_lock();
        test_rotated(17, k_next);
        test_shift_relock(k_next);
        test_rotated(59, k_next);
        test_reset_locked();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
